id_ex_stage: RTL

//  ID/EX pipeline stage of the 5-stage MIPS core; sits directly upstream of the EX-stage ALU and drives its a/b/alu_ctrl.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/id_ex_stage_if.sv | 67 ++++++
 rtl/alu_ctrl_dec.sv | 32 +++
 rtl/id_ex_stage.sv | 115 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared ALU op encodings, main-decoder ALU-op codes, funct codes and the EX control bundle.
// Used by the ID/EX stage and its ALU-control decoder.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side fields, stall/flush and EX-side registered outputs of the ID/EX stage.
// ID_EX_PERF_CNT_EN adds perf_issued/perf_bubbles.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [15:0]       id_imm16;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [1:0]        id_alu_op;
    logic              id_alu_src;
    logic              id_reg_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              id_branch;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_alu_a;
    logic [DATA_W-1:0] ex_alu_b;
    logic [3:0]        ex_alu_ctrl;
    logic [DATA_W-1:0] ex_store_data;
    logic [DATA_W-1:0] ex_imm_ext;
    logic [DATA_W-1:0] ex_pc4;
    logic [REG_AW-1:0] ex_wr_reg;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              ex_branch;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]       perf_issued;
    logic [31:0]       perf_bubbles;
`endif

    modport master (
        output stall, flush, id_valid, id_pc4, id_rs_data, id_rt_data, id_imm16,
               id_rt, id_rd, id_alu_op, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, id_branch,
        input  ex_valid, ex_alu_a, ex_alu_b, ex_alu_ctrl, ex_store_data, ex_imm_ext,
               ex_pc4, ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_branch
`ifdef ID_EX_PERF_CNT_EN
        , input perf_issued, perf_bubbles
`endif
    );

    modport slave (
        input  stall, flush, id_valid, id_pc4, id_rs_data, id_rt_data, id_imm16,
               id_rt, id_rd, id_alu_op, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, id_branch,
        output ex_valid, ex_alu_a, ex_alu_b, ex_alu_ctrl, ex_store_data, ex_imm_ext,
               ex_pc4, ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_branch
`ifdef ID_EX_PERF_CNT_EN
        , output perf_issued, perf_bubbles
`endif
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: alu_op + funct -> 4-bit ALU op select.
// Purely combinational, zero latency; no flow control.
// Unrecognised R-type funct maps to ALU_NOP so the ALU yields 0 without trapping.
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_NOP;
        unique case (alu_op)
            ALUOP_ADD:   alu_ctrl = ALU_ADD;
            ALUOP_SUB:   alu_ctrl = ALU_SUB;
            ALUOP_RSVD:  alu_ctrl = ALU_ADD;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = ALU_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    FUNCT_SLT: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_NOP;
                endcase
            end
            default:     alu_ctrl = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU op, muxes operand b and dest reg, registers for EX.
// Latency 1 cycle; stall holds every EX register, flush (wins over stall) loads a bubble.
// ID_EX_PERF_CNT_EN adds wrapping issued/bubble counters that freeze while stalled.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_b_mux;
    logic [REG_AW-1:0] wr_reg_mux;
    logic [3:0]        alu_ctrl_dec_out;
    logic              advance;
    logic              bubble;

    ex_ctrl_t          ctrl_q;
    logic [3:0]        alu_ctrl_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [DATA_W-1:0] store_data_q;
    logic [DATA_W-1:0] imm_ext_q;
    logic [DATA_W-1:0] pc4_q;
    logic [REG_AW-1:0] wr_reg_q;

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op   (bus.id_alu_op),
        .funct    (bus.id_imm16[5:0]),
        .alu_ctrl (alu_ctrl_dec_out)
    );

    assign imm_ext    = {{(DATA_W-16){bus.id_imm16[15]}}, bus.id_imm16};
    assign alu_b_mux  = bus.id_alu_src ? imm_ext : bus.id_rt_data;
    assign wr_reg_mux = bus.id_reg_dst ? bus.id_rd : bus.id_rt;

    // flush overrides stall; an empty ID slot loads exactly like a flush
    assign advance = bus.flush || !bus.stall;
    assign bubble  = bus.flush || !bus.id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q       <= '0;
            alu_ctrl_q   <= 4'b0000;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            store_data_q <= '0;
            imm_ext_q    <= '0;
            pc4_q        <= '0;
            wr_reg_q     <= '0;
        end else if (advance) begin
            if (bubble) begin
                ctrl_q       <= '0;
                alu_ctrl_q   <= ALU_NOP;
                alu_a_q      <= '0;
                alu_b_q      <= '0;
                store_data_q <= '0;
                imm_ext_q    <= '0;
                pc4_q        <= '0;
                wr_reg_q     <= '0;
            end else begin
                ctrl_q.valid      <= 1'b1;
                ctrl_q.reg_write  <= bus.id_reg_write;
                ctrl_q.mem_read   <= bus.id_mem_read;
                ctrl_q.mem_write  <= bus.id_mem_write;
                ctrl_q.mem_to_reg <= bus.id_mem_to_reg;
                ctrl_q.branch     <= bus.id_branch;
                alu_ctrl_q        <= alu_ctrl_dec_out;
                alu_a_q           <= bus.id_rs_data;
                alu_b_q           <= alu_b_mux;
                store_data_q      <= bus.id_rt_data;
                imm_ext_q         <= imm_ext;
                pc4_q             <= bus.id_pc4;
                wr_reg_q          <= wr_reg_mux;
            end
        end
    end

    assign bus.ex_valid      = ctrl_q.valid;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ex_branch     = ctrl_q.branch;
    assign bus.ex_alu_ctrl   = alu_ctrl_q;
    assign bus.ex_alu_a      = alu_a_q;
    assign bus.ex_alu_b      = alu_b_q;
    assign bus.ex_store_data = store_data_q;
    assign bus.ex_imm_ext    = imm_ext_q;
    assign bus.ex_pc4        = pc4_q;
    assign bus.ex_wr_reg     = wr_reg_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_bubbles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued_q  <= '0;
            perf_bubbles_q <= '0;
        end else if (advance) begin
            if (bubble) perf_bubbles_q <= perf_bubbles_q + 32'd1;
            else        perf_issued_q  <= perf_issued_q + 32'd1;
        end
    end

    assign bus.perf_issued  = perf_issued_q;
    assign bus.perf_bubbles = perf_bubbles_q;
`endif

endmodule
